reg_list_sequencer: RTL and testbench

//   Iterates an LDM/STM 16-bit register list one register per accepted cycle, lowest index first.

---
 rtl/reg_list_sequencer.sv | 124 ++++++++++++
 tb/tb_reg_list_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer: walks an LDM/STM register list lowest index first, one register per Advance
//   Clk, Reset                   clock and synchronous active-high reset
//   Start, RegList, BaseAddr     transfer request; list and base are latched when Start is accepted in IDLE
//   Up, Before                   U/P addressing bits (IA, IB, DA, DB)
//   Advance                      consumer accepts the current register
//   Busy, Valid, Done            state decode: ISSUE or DONE / ISSUE / DONE
//   RegNum, RegOneHot, Addr      current register, its one-hot mask and its transfer address
//   Last                         current register is the final one in the list
//   Count, WbAddr                register count and base writeback value of the latched transfer
module reg_list_sequencer #(
    parameter int LIST_W = 16,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [LIST_W-1:0] RegList,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              Up,
    input  logic              Before,
    input  logic              Advance,
    output logic              Busy,
    output logic              Valid,
    output logic [IDX_W-1:0]  RegNum,
    output logic [LIST_W-1:0] RegOneHot,
    output logic [ADDR_W-1:0] Addr,
    output logic              Last,
    output logic              Done,
    output logic [IDX_W:0]    Count,
    output logic [ADDR_W-1:0] WbAddr
);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [LIST_W-1:0] rem_q, rem_d, onehot_q, onehot_d;
    logic [IDX_W-1:0]  num_q, num_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wb_q, wb_d, start_off;
    logic [CNT_W-1:0]  cnt_q, cnt_d, start_cnt;
    logic              last_q, last_d;

    function automatic logic [CNT_W-1:0] popcnt(input logic [LIST_W-1:0] v);
        popcnt = '0;
        for (int i = 0; i < LIST_W; i++)
            popcnt = popcnt + CNT_W'(v[i]);
    endfunction

    // Scanning downward lets the lowest set bit win.
    function automatic logic [IDX_W-1:0] penc(input logic [LIST_W-1:0] v);
        penc = '0;
        for (int i = LIST_W - 1; i >= 0; i--)
            if (v[i]) penc = IDX_W'(i);
    endfunction

    assign start_cnt = popcnt(RegList);
    assign start_off = ADDR_W'(start_cnt) << 2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            onehot_q <= '0;
            num_q    <= '0;
            addr_q   <= '0;
            wb_q     <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            onehot_q <= onehot_d;
            num_q    <= num_d;
            addr_q   <= addr_d;
            wb_q     <= wb_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    // The per-register outputs are derived from the next remaining list,
    // so they appear registered in the same cycle the state enters or stays in ISSUE.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        wb_d    = wb_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (Start) begin
                rem_d   = RegList;
                cnt_d   = start_cnt;
                wb_d    = Up ? BaseAddr + start_off : BaseAddr - start_off;
                // Decrementing modes start at the bottom of the block; an extra word is added for IB and DA.
                addr_d  = (Up ? BaseAddr : BaseAddr - start_off) + ((Up == Before) ? ADDR_W'(4) : '0);
                state_d = (RegList != '0) ? ISSUE : DONE;
            end
            ISSUE: if (Advance) begin
                rem_d   = rem_q & ~onehot_q;
                addr_d  = addr_q + ADDR_W'(4);
                state_d = (rem_d == '0) ? DONE : ISSUE;
            end
            default: state_d = IDLE;
        endcase
        num_d    = (state_d == ISSUE) ? penc(rem_d) : '0;
        onehot_d = (state_d == ISSUE) ? LIST_W'(1) << num_d : '0;
        last_d   = (state_d == ISSUE) && (popcnt(rem_d) == CNT_W'(1));
        addr_d   = (state_d == ISSUE) ? addr_d : '0;
    end

    always_comb begin
        Busy  = state_q != IDLE;
        Valid = state_q == ISSUE;
        Done  = state_q == DONE;
    end

    assign RegNum    = num_q;
    assign RegOneHot = onehot_q;
    assign Addr      = addr_q;
    assign Last      = last_q;
    assign Count     = cnt_q;
    assign WbAddr    = wb_q;
endmodule

// File: tb/tb_reg_list_sequencer.sv
// tb_reg_list_sequencer: directed and randomized transfers against a list-based reference model
module tb_reg_list_sequencer;
    logic        Clk = 1'b0;
    logic        Reset, Start, Up, Before, Advance;
    logic [15:0] RegList;
    logic [31:0] BaseAddr;
    logic        Busy, Valid, Last, Done;
    logic [3:0]  RegNum;
    logic [15:0] RegOneHot;
    logic [31:0] Addr, WbAddr;
    logic [4:0]  Count;

    int n_tests = 0;
    int n_fail  = 0;

    reg_list_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .RegList(RegList), .BaseAddr(BaseAddr),
        .Up(Up), .Before(Before), .Advance(Advance), .Busy(Busy), .Valid(Valid),
        .RegNum(RegNum), .RegOneHot(RegOneHot), .Addr(Addr), .Last(Last), .Done(Done),
        .Count(Count), .WbAddr(WbAddr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 32'(Busy), 0);
        check({tag, ".valid"}, 32'(Valid), 0);
        check({tag, ".done"}, 32'(Done), 0);
        check({tag, ".last"}, 32'(Last), 0);
        check({tag, ".regnum"}, 32'(RegNum), 0);
        check({tag, ".onehot"}, 32'(RegOneHot), 0);
        check({tag, ".addr"}, Addr, 0);
        check({tag, ".count"}, 32'(Count), 0);
        check({tag, ".wb"}, WbAddr, 0);
    endtask

    // mode 0: Advance always high; 1: random Advance and spurious Start; 2: 3-cycle stall on the second register with Start pulsed
    task automatic run_txn(input logic [15:0] lst, input logic [31:0] base, input logic up,
                           input logic bf, input int mode);
        int q[$];
        int n, k, stall;
        logic [31:0] a0, wb, blk;
        logic adv;
        for (int i = 0; i < 16; i++)
            if (lst[i]) q.push_back(i);
        n   = q.size();
        blk = 32'(4 * n);
        wb  = up ? base + blk : base - blk;
        if (up) a0 = bf ? base + 32'd4 : base;
        else    a0 = bf ? base - blk : base - blk + 32'd4;
        RegList  = lst;
        BaseAddr = base;
        Up       = up;
        Before   = bf;
        Start    = 1'b1;
        Advance  = 1'($urandom);
        @(negedge Clk);
        Start    = 1'b0;
        RegList  = 16'($urandom);
        BaseAddr = $urandom;
        Up       = 1'($urandom);
        Before   = 1'($urandom);
        k = 0;
        stall = 0;
        while (k < n) begin
            check("issue.valid", 32'(Valid), 1);
            check("issue.busy", 32'(Busy), 1);
            check("issue.done", 32'(Done), 0);
            check("issue.regnum", 32'(RegNum), 32'(q[k]));
            check("issue.onehot", 32'(RegOneHot), 32'(1) << q[k]);
            check("issue.addr", Addr, a0 + 32'(4 * k));
            check("issue.last", 32'(Last), 32'(k == n - 1));
            check("issue.count", 32'(Count), 32'(n));
            check("issue.wb", WbAddr, wb);
            Start = 1'b0;
            if (mode == 1) begin
                adv   = ($urandom % 3) != 0;
                Start = ($urandom % 4) == 0;
            end else if (mode == 2 && k == 1 && stall < 3) begin
                adv   = 1'b0;
                Start = 1'b1;
                stall++;
            end else begin
                adv = 1'b1;
            end
            Advance = adv;
            @(negedge Clk);
            if (adv) k++;
        end
        check("done.done", 32'(Done), 1);
        check("done.valid", 32'(Valid), 0);
        check("done.busy", 32'(Busy), 1);
        check("done.onehot", 32'(RegOneHot), 0);
        check("done.count", 32'(Count), 32'(n));
        check("done.wb", WbAddr, wb);
        Start   = (mode == 1) ? 1'($urandom) : 1'b0;
        Advance = 1'($urandom);
        @(negedge Clk);
        check("idle.busy", 32'(Busy), 0);
        check("idle.done", 32'(Done), 0);
        check("idle.valid", 32'(Valid), 0);
        check("idle.count", 32'(Count), 32'(n));
        check("idle.wb", WbAddr, wb);
        Start   = 1'b0;
        Advance = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Up = 1'b0; Before = 1'b0; Advance = 1'b0;
        RegList = '0; BaseAddr = '0;
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        Start = 1'b1; RegList = 16'hFFFF; BaseAddr = 32'h1234; Up = 1'b1; Advance = 1'b1;
        @(negedge Clk);
        check_all_zero("reset_start");
        Reset = 1'b0; Start = 1'b0; Advance = 1'b0;
        @(negedge Clk);
        check_all_zero("post_reset");

        run_txn(16'h0811, 32'h100, 1'b1, 1'b0, 0);
        run_txn(16'hC000, 32'h200, 1'b0, 1'b1, 0);
        run_txn(16'h0811, 32'h100, 1'b1, 1'b0, 2);
        run_txn(16'h0000, 32'h40, 1'b1, 1'b0, 0);
        run_txn(16'h0003, 32'hFFFFFFFC, 1'b1, 1'b0, 0);
        run_txn(16'hFFFF, 32'h1000, 1'b0, 1'b0, 0);
        run_txn(16'h8001, 32'h8, 1'b0, 1'b1, 0);

        RegList = 16'h0003; BaseAddr = 32'hFFFFFFFC; Up = 1'b1; Before = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Advance = 1'b1;
        @(negedge Clk);
        check("mid.regnum", 32'(RegNum), 1);
        check("mid.addr", Addr, 0);
        Reset = 1'b1;
        @(negedge Clk);
        check_all_zero("mid_reset");
        Reset = 1'b0; Advance = 1'b0;
        run_txn(16'h0024, 32'h300, 1'b1, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] l;
            l = 16'($urandom);
            if (t % 5 == 0) l = l & 16'($urandom) & 16'($urandom);
            if (t % 13 == 0) l = '0;
            run_txn(l, $urandom, 1'($urandom), 1'($urandom), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
